// File: rtl/list_pkg.sv
// ---------------------------------------------------------------------------
// list_pkg
// Shared definitions for the req/ack lazy-list fabric.
//   concat_state_t : controller states of the N-way concatenator
//   ELEM_VALID     : value_valid level that accompanies a real element
//   ELEM_END       : value_valid level that, together with ack, ends a list
//   idx_width()    : width of a channel index for an n-way block (minimum 1)
// ---------------------------------------------------------------------------
package list_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // waiting for a downstream request
        FETCH = 3'd1,   // ch_req[sel] high, waiting for ch_ack[sel]
        NEXT  = 3'd2,   // gap cycle between channels, sel advances
        RESP  = 3'd3,   // ack pulse to the consumer
        DONE  = 3'd4    // every channel exhausted
    } concat_state_t;

    localparam logic ELEM_VALID = 1'b1;
    localparam logic ELEM_END   = 1'b0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_edge.sv
// ---------------------------------------------------------------------------
// req_edge
// Rising-edge detector for a list request line.
//   clock, reset_n : clock and asynchronous active-low reset
//   ready          : session enable; while low no edge is reported
//   req            : request level from the consumer
//   last_req       : req as sampled at the previous rising edge
//   rise           : combinational, req high now and low last cycle
// ---------------------------------------------------------------------------
module req_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic ready,
    input  logic req,
    output logic last_req,
    output logic rise
);

    // A session clear also tracks req, so a request held high across the
    // clear is not mistaken for a new edge afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_req <= 1'b0;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every register samples pre-edge values, whatever the order.
            last_req <= req;
        end
    end

    assign rise = ready & req & ~last_req;

endmodule

// File: rtl/list_concat_n.sv
// ---------------------------------------------------------------------------
// list_concat_n
// N-way lazy-list concatenator: channel 0's elements, then channel 1's, ...,
// then end-of-list. Exhausted channels are skipped inside one downstream
// request. All outputs are registered.
//   clock, reset_n   : clock, asynchronous active-low reset
//   ready            : session enable, low = synchronous clear
//   ch_req / ch_ack  : per-channel upstream handshake (ch_req one-hot or 0)
//   ch_value         : channel i element at [i*WIDTH +: WIDTH]
//   ch_value_valid   : 0 with ch_ack marks that channel as exhausted
//   req / ack        : downstream request (rising edge) and response pulse
//   value            : element, held between acks
//   value_valid      : 0 with ack marks end of the concatenated list
//   index            : source channel of value
//   count            : valid elements delivered this session (saturating)
// ---------------------------------------------------------------------------
module list_concat_n
    import list_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 16,
    localparam int IDX_W = idx_width(N)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ready,
    output logic [N-1:0]       ch_req,
    input  logic [N-1:0]       ch_ack,
    input  logic [N*WIDTH-1:0] ch_value,
    input  logic [N-1:0]       ch_value_valid,
    input  logic               req,
    output logic               ack,
    output logic [WIDTH-1:0]   value,
    output logic               value_valid,
    output logic [IDX_W-1:0]   index,
    output logic [CNT_W-1:0]   count
);

    concat_state_t    state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [N-1:0]     ch_req_d;
    logic             ack_d;
    logic [WIDTH-1:0] value_d;
    logic             value_valid_d;
    logic [IDX_W-1:0] index_d;
    logic [CNT_W-1:0] count_d;

    logic             last_req;
    logic             rise;
    logic             sel_ack;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_value;
    logic             sel_is_last;

    req_edge u_req_edge (
        .clock    (clock),
        .reset_n  (reset_n),
        .ready    (ready),
        .req      (req),
        .last_req (last_req),
        .rise     (rise)
    );

    // Only the selected channel is looked at; acks elsewhere are ignored.
    assign sel_ack     = ch_ack[sel_q];
    assign sel_valid   = ch_value_valid[sel_q];
    assign sel_value   = ch_value[int'(sel_q) * WIDTH +: WIDTH];
    assign sel_is_last = (sel_q == IDX_W'(N - 1));

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] s);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = (s == IDX_W'(i));
        end
        return v;
    endfunction

    always_comb begin
        // NOTE: every next value is defaulted before the case so that no
        // path leaves a variable unassigned, which would infer a latch.
        state_d       = state_q;
        sel_d         = sel_q;
        ch_req_d      = ch_req;
        ack_d         = 1'b0;
        value_d       = value;
        value_valid_d = value_valid;
        index_d       = index;
        count_d       = count;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    ch_req_d = onehot(sel_q);
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (sel_ack) begin
                    // Drop the request right after the ack so the next fetch
                    // from this channel starts with a fresh rising edge.
                    ch_req_d = '0;
                    if (sel_valid == ELEM_VALID) begin
                        value_d       = sel_value;
                        value_valid_d = ELEM_VALID;
                        index_d       = sel_q;
                        if (count != '1) begin
                            count_d = count + 1'b1;
                        end
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end else if (!sel_is_last) begin
                        // Same downstream request continues on the next channel.
                        state_d = NEXT;
                    end else begin
                        value_valid_d = ELEM_END;
                        ack_d         = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            NEXT: begin
                sel_d    = sel_q + 1'b1;
                ch_req_d = onehot(sel_q + 1'b1);
                state_d  = FETCH;
            end
            RESP: begin
                // value_valid low here means the list just ended.
                state_d = (value_valid == ELEM_VALID) ? IDLE : DONE;
            end
            DONE: begin
                if (rise) begin
                    value_valid_d = ELEM_END;
                    ack_d         = 1'b1;
                    state_d       = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: value/index are single output registers, not a storage array,
    // so they are reset along with the rest of the visible state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ch_req      <= '0;
            ack         <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            index       <= '0;
            count       <= '0;
        end else if (!ready) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ch_req      <= '0;
            ack         <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            index       <= '0;
            count       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ch_req      <= ch_req_d;
            ack         <= ack_d;
            value       <= value_d;
            value_valid <= value_valid_d;
            index       <= index_d;
            count       <= count_d;
        end
    end

endmodule

// File: tb/tb_list_concat_n.sv
// ---------------------------------------------------------------------------
// tb_list_concat_n
// Drives a 2-way and a 3-way concatenator (one active at a time) from a
// shared upstream responder and checks every downstream response against a
// list-level reference model: per-channel element queues walked in order.
// ---------------------------------------------------------------------------
module tb_list_concat_n;

    typedef struct packed {
        logic        got;
        logic        vv;
        logic [7:0]  value;
        logic [1:0]  index;
        logic [15:0] count;
        logic [7:0]  lat;
    } resp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic ready   = 1'b0;
    logic req     = 1'b0;
    logic use3    = 1'b0;

    // 2-way instance
    logic [1:0]  ch_req2, ch_ack2, ch_vv2;
    logic [15:0] ch_value2;
    logic        req2, ack2, vv2;
    logic [7:0]  value2;
    logic [0:0]  index2;
    logic [15:0] count2;

    // 3-way instance
    logic [2:0]  ch_req3, ch_ack3, ch_vv3;
    logic [23:0] ch_value3;
    logic        req3, ack3, vv3;
    logic [7:0]  value3;
    logic [1:0]  index3;
    logic [15:0] count3;

    // Upstream responder state
    logic [2:0]  act_req;
    logic [2:0]  rsp_ack   = '0;
    logic [2:0]  rsp_vv    = '0;
    logic [23:0] rsp_val   = '0;
    logic [2:0]  hold_mask = '0;
    logic [2:0]  stray     = '0;
    logic [2:0]  prev_req  = '0;
    logic [2:0]  first_seen = '0;
    bit          served[3];
    int          pulses[3];
    int          src_q[3][$];

    // Muxed downstream view of the active instance
    logic        m_ack, m_vv;
    logic [7:0]  m_value;
    logic [1:0]  m_index;
    logic [15:0] m_count;
    int          ack_total = 0;
    logic [7:0]  last_ack_value = '0;

    // Reference model
    int          mq[3][$];
    int          m_n, m_sel, m_count_ref, m_last_v, m_last_idx;
    bit          m_done;

    int tests  = 0;
    int failed = 0;

    assign req2      = use3 ? 1'b0 : req;
    assign req3      = use3 ? req : 1'b0;
    assign ch_ack2   = use3 ? 2'b00 : rsp_ack[1:0];
    assign ch_ack3   = use3 ? (rsp_ack | stray) : 3'b000;
    assign ch_value2 = rsp_val[15:0];
    assign ch_vv2    = rsp_vv[1:0];
    assign ch_value3 = rsp_val;
    assign ch_vv3    = rsp_vv;
    assign act_req   = use3 ? ch_req3 : {1'b0, ch_req2};
    assign m_ack     = use3 ? ack3 : ack2;
    assign m_vv      = use3 ? vv3 : vv2;
    assign m_value   = use3 ? value3 : value2;
    assign m_index   = use3 ? index3 : {1'b0, index2};
    assign m_count   = use3 ? count3 : count2;

    list_concat_n #(.N(2), .WIDTH(8), .CNT_W(16)) dut2 (
        .clock (clock), .reset_n (reset_n), .ready (ready),
        .ch_req (ch_req2), .ch_ack (ch_ack2), .ch_value (ch_value2),
        .ch_value_valid (ch_vv2), .req (req2), .ack (ack2), .value (value2),
        .value_valid (vv2), .index (index2), .count (count2)
    );

    list_concat_n #(.N(3), .WIDTH(8), .CNT_W(16)) dut3 (
        .clock (clock), .reset_n (reset_n), .ready (ready),
        .ch_req (ch_req3), .ch_ack (ch_ack3), .ch_value (ch_value3),
        .ch_value_valid (ch_vv3), .req (req3), .ack (ack3), .value (value3),
        .value_valid (vv3), .index (index3), .count (count3)
    );

    initial forever #5 clock = ~clock;

    // Upstream producer: sees ch_req one edge, acks for one cycle after the
    // next edge, popping its element queue (empty queue = exhausted).
    initial forever begin
        @(posedge clock);
        #1;
        rsp_ack = '0;
        rsp_val = 24'($urandom);
        rsp_vv  = 3'($urandom);
        if (first_seen == 3'b000 && act_req != 3'b000) first_seen = act_req;
        for (int i = 0; i < 3; i++) begin
            if (act_req[i] && !prev_req[i]) pulses[i]++;
            if (!act_req[i]) begin
                served[i] = 1'b0;
            end else if (prev_req[i] && !served[i] && !hold_mask[i]) begin
                rsp_ack[i] = 1'b1;
                served[i]  = 1'b1;
                if (src_q[i].size() > 0) begin
                    rsp_val[i*8 +: 8] = 8'(src_q[i].pop_front());
                    rsp_vv[i] = 1'b1;
                end else begin
                    rsp_vv[i] = 1'b0;
                end
            end
        end
        prev_req = act_req;
    end

    initial forever begin
        @(negedge clock);
        if (m_ack === 1'b1) begin
            ack_total++;
            last_ack_value = m_value;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic string fmt(resp_t r);
        return $sformatf("ack=%0b valid=%0b value=%0d index=%0d count=%0d latency=%0d",
                         r.got, r.vv, r.value, r.index, r.count, r.lat);
    endfunction

    task automatic push(input int ch, input int v);
        src_q[ch].push_back(v);
        mq[ch].push_back(v);
    endtask

    // New session in the model; queued elements are kept.
    task automatic model_session(input int n);
        m_n = n; m_sel = 0; m_done = 0; m_count_ref = 0;
        m_last_v = 0; m_last_idx = 0;
    endtask

    // Expected response to one downstream request: walk channels in order,
    // each channel visit costs 3 cycles; after the end every request costs 1.
    task automatic model_next(output resp_t e);
        int fetches = 0;
        bit stop = 0;
        e = '0;
        e.got = 1'b1;
        if (m_done) begin
            e.vv  = 1'b0;
            e.lat = 8'd1;
        end else begin
            while (!stop) begin
                fetches++;
                if (mq[m_sel].size() > 0) begin
                    m_last_v   = mq[m_sel].pop_front();
                    m_last_idx = m_sel;
                    m_count_ref++;
                    e.vv = 1'b1;
                    stop = 1;
                end else if (m_sel == m_n - 1) begin
                    m_done = 1;
                    e.vv   = 1'b0;
                    stop   = 1;
                end else begin
                    m_sel++;
                end
            end
            e.lat = 8'(3 * fetches);
        end
        e.value = 8'(m_last_v);
        e.index = 2'(m_last_idx);
        e.count = 16'(m_count_ref);
    endtask

    task automatic session_clear(input logic three);
        @(negedge clock);
        use3 = three; req = 1'b0; hold_mask = '0; stray = '0; ready = 1'b0;
        @(negedge clock);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_q[i].delete();
            mq[i].delete();
            pulses[i] = 0;
        end
        first_seen = '0;
        model_session(three ? 3 : 2);
    endtask

    task automatic start_req();
        @(negedge clock);
        req = 1'b1;
    endtask

    task automatic wait_ack(output bit got, output int cyc);
        got = 0;
        cyc = 0;
        while (!got && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (m_ack === 1'b1) got = 1;
        end
        req = 1'b0;
    endtask

    task automatic do_req(output resp_t r);
        bit got;
        int cyc;
        start_req();
        wait_ack(got, cyc);
        r.got   = got;
        r.vv    = m_vv;
        r.value = m_value;
        r.index = m_index;
        r.count = m_count;
        r.lat   = 8'(cyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if ({ch_req3, ack3, value3, vv3, index3, count3} !== '0) begin
            failed++;
            $display("FAIL reset_n3: ch_req=%b ack=%b value=%0d valid=%b index=%0d count=%0d, want all 0",
                     ch_req3, ack3, value3, vv3, index3, count3);
        end
        tests++;
        if ({ch_req2, ack2, value2, vv2, index2, count2} !== '0) begin
            failed++;
            $display("FAIL reset_n2: ch_req=%b ack=%b value=%0d valid=%b index=%0d count=%0d, want all 0",
                     ch_req2, ack2, value2, vv2, index2, count2);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_two_way();
        resp_t e, o;
        session_clear(1'b0);
        push(0, 1); push(0, 2); push(1, 5);
        for (int k = 0; k < 4; k++) begin
            model_next(e);
            do_req(o);
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL two_way[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
        end
        tests++;
        if (count2 !== 16'd3) begin
            failed++;
            $display("FAIL two_way_count: count=%0d, want 3", count2);
        end
    endtask

    task automatic test_skip_empty();
        resp_t e, o;
        int acks0;
        session_clear(1'b1);
        push(0, 7); push(2, 9);
        acks0 = ack_total;
        for (int k = 0; k < 3; k++) begin
            model_next(e);
            do_req(o);
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL skip_empty[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
        end
        repeat (3) @(negedge clock);
        tests++;
        if (pulses[1] != 1) begin
            failed++;
            $display("FAIL skip_empty_ch1_pulses: %0d, want 1", pulses[1]);
        end
        tests++;
        if (ack_total - acks0 != 3) begin
            failed++;
            $display("FAIL skip_empty_acks: %0d, want 3", ack_total - acks0);
        end
    endtask

    task automatic test_all_empty();
        resp_t e, o;
        session_clear(1'b1);
        model_next(e);
        do_req(o);
        tests++;
        if (o !== e) begin
            failed++;
            $display("FAIL all_empty_first: got %s, want %s", fmt(o), fmt(e));
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (pulses[i] != 1) begin
                failed++;
                $display("FAIL all_empty_pulses[%0d]: %0d, want 1", i, pulses[i]);
            end
        end
        model_next(e);
        do_req(o);
        tests++;
        if (o !== e) begin
            failed++;
            $display("FAIL all_empty_done: got %s, want %s", fmt(o), fmt(e));
        end
        tests++;
        if (pulses[0] + pulses[1] + pulses[2] != 3) begin
            failed++;
            $display("FAIL all_empty_no_req: pulses=%0d, want 3",
                     pulses[0] + pulses[1] + pulses[2]);
        end
    endtask

    task automatic test_ready_clear();
        resp_t e, o;
        int cyc;
        session_clear(1'b1);
        push(0, 3); push(1, 4);
        model_next(e);
        do_req(o);
        tests++;
        if (o !== e) begin
            failed++;
            $display("FAIL ready_first: got %s, want %s", fmt(o), fmt(e));
        end
        hold_mask = 3'b010;
        start_req();
        cyc = 0;
        while (ch_req3[1] !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        tests++;
        if (ch_req3[1] !== 1'b1) begin
            failed++;
            $display("FAIL ready_fetch_ch1: ch_req=%b, want bit 1 set", ch_req3);
        end
        ready = 1'b0;
        @(negedge clock);
        tests++;
        if (ch_req3 !== 3'b000 || count3 !== 16'd0) begin
            failed++;
            $display("FAIL ready_clear: ch_req=%b count=%0d, want 000 and 0", ch_req3, count3);
        end
        ready = 1'b1; req = 1'b0; hold_mask = '0; first_seen = '0;
        model_session(3);
        model_next(e);
        do_req(o);
        tests++;
        if (first_seen !== 3'b001) begin
            failed++;
            $display("FAIL ready_restart_ch: first ch_req=%b, want 001", first_seen);
        end
        tests++;
        if (o !== e) begin
            failed++;
            $display("FAIL ready_restart: got %s, want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_back_to_back();
        resp_t e, o;
        int cyc, acks0;
        session_clear(1'b1);
        push(0, 11); push(0, 12);
        hold_mask = 3'b001;
        acks0 = ack_total;
        model_next(e);
        start_req();
        cyc = 0;
        while (ch_req3[0] !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        tests++;
        if (ch_req3[0] !== 1'b1) begin
            failed++;
            $display("FAIL b2b_fetch: ch_req=%b, want bit 0 set", ch_req3);
        end
        @(negedge clock); req = 1'b0;
        @(negedge clock); req = 1'b1; stray = 3'b100;
        @(negedge clock); stray = 3'b000; hold_mask = '0;
        repeat (10) @(negedge clock);
        req = 1'b0;
        repeat (5) @(negedge clock);
        tests++;
        if (ack_total - acks0 != 1 || last_ack_value !== e.value) begin
            failed++;
            $display("FAIL b2b_single_ack: acks=%0d value=%0d, want 1 and %0d",
                     ack_total - acks0, last_ack_value, e.value);
        end
        model_next(e);
        do_req(o);
        tests++;
        if (o !== e) begin
            failed++;
            $display("FAIL b2b_next: got %s, want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_mid_resp();
        resp_t e;
        bit got;
        int cyc;
        session_clear(1'b1);
        push(0, 21);
        model_next(e);
        start_req();
        wait_ack(got, cyc);
        tests++;
        if (!got || m_vv !== 1'b1 || m_value !== e.value || m_count !== 16'd1) begin
            failed++;
            $display("FAIL mid_resp_pre: ack=%0b valid=%b value=%0d count=%0d, want 1 1 %0d 1",
                     got, m_vv, m_value, m_count, e.value);
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if (m_ack !== 1'b0 || m_vv !== 1'b0 || m_count !== 16'd0) begin
            failed++;
            $display("FAIL mid_resp_reset: ack=%b valid=%b count=%0d, want 0 0 0",
                     m_ack, m_vv, m_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        resp_t e, o;
        int total, len, nreq;
        for (int r = 0; r < 6; r++) begin
            session_clear(1'b1);
            total = 0;
            for (int ch = 0; ch < 3; ch++) begin
                len = $urandom_range(0, 3);
                for (int k = 0; k < len; k++) push(ch, $urandom_range(0, 255));
                total += len;
            end
            nreq = total + 2;
            for (int k = 0; k < nreq; k++) begin
                model_next(e);
                do_req(o);
                tests++;
                if (o !== e) begin
                    failed++;
                    $display("FAIL random[%0d.%0d]: got %s, want %s", r, k, fmt(o), fmt(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_way();
        test_skip_empty();
        test_all_empty();
        test_ready_clear();
        test_back_to_back();
        test_reset_mid_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
